// File: rtl/car_pixel_engine_if.sv
// Request/move strobes from the race control FSM and pixel/handshake results back from the engine.
interface car_pixel_engine_if;
   logic       draw_car;
   logic       clear;
   logic       drive;
   logic       straight;
   logic       left;
   logic       right;
   logic       resetsignal;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       done_car;
   logic       done_clear;
   logic       done_race;
   logic [7:0] car_x;
   logic [6:0] car_y;

   modport master (
      output draw_car, clear, drive, straight, left, right, resetsignal,
      input  vga_x, vga_y, vga_colour, vga_plot, done_car, done_clear, done_race, car_x, car_y
   );

   modport slave (
      input  draw_car, clear, drive, straight, left, right, resetsignal,
      output vga_x, vga_y, vga_colour, vga_plot, done_car, done_clear, done_race, car_x, car_y
   );
endinterface

// File: rtl/car_pixel_engine.sv
// Car position/move datapath plus sprite rasteriser, one registered pixel per clock (first plot 1 cycle after IDLE),
// no backpressure; done_* held until the request drops. CAR_TRANSPARENT_EN skips wheel pixels in DRAW.
module car_pixel_engine #(
   parameter int         CAR_W      = 8,
   parameter int         CAR_H      = 12,
   parameter int         START_X    = 76,
   parameter int         START_Y    = 100,
   parameter int         STEP_X     = 4,
   parameter int         STEP_Y     = 2,
   parameter int         X_MIN      = 20,
   parameter int         X_MAX      = 132,
   parameter int         FINISH_Y   = 8,
   parameter logic [2:0] CAR_COLOUR = 3'b100,
   parameter logic [2:0] BG_COLOUR  = 3'b010
) (
   input logic               clock,
   input logic               resetn,
   car_pixel_engine_if.slave bus
);
   localparam int CXW = (CAR_W > 1) ? $clog2(CAR_W) : 1;
   localparam int CYW = (CAR_H > 1) ? $clog2(CAR_H) : 1;
   localparam logic [CXW-1:0] CX_LAST = CXW'(CAR_W - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(CAR_H - 1);
   localparam logic [CYW-1:0] CY_TOP  = CYW'(3);
   localparam logic [CYW-1:0] CY_BOT  = CYW'(CAR_H - 3);

   typedef enum logic [1:0] {IDLE, DRAW, ERASE, DONE} state_t;

   state_t         state, state_nxt;
   logic [CXW-1:0] cx;
   logic [CYW-1:0] cy;
   logic           mode_draw;
   logic [7:0]     car_x, x_nxt;
   logic [6:0]     car_y, y_nxt;
   logic [7:0]     vga_x;
   logic [6:0]     vga_y;
   logic [2:0]     vga_colour, colour_d;
   logic           vga_plot, done_car, done_clear, done_race;
   logic           req, last_px, raster, wheel, plot_d, done_d, move_en;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      req       = mode_draw ? bus.draw_car : bus.clear;
      last_px   = (cx == CX_LAST) && (cy == CY_LAST);
      state_nxt = state;
      if (bus.resetsignal) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:        if (bus.clear) state_nxt = ERASE;
                         else if (bus.draw_car) state_nxt = DRAW;
            DRAW, ERASE: if (last_px) state_nxt = DONE;
            // done is guaranteed at least one visible cycle before returning to IDLE
            DONE:        if ((done_car || done_clear) && !req) state_nxt = IDLE;
            default:     state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      raster   = (state == DRAW) || (state == ERASE);
      wheel    = ((cx == '0) || (cx == CX_LAST)) && ((cy < CY_TOP) || (cy >= CY_BOT));
      colour_d = (state == ERASE) ? BG_COLOUR : (wheel ? 3'b000 : CAR_COLOUR);
`ifdef CAR_TRANSPARENT_EN
      plot_d   = raster && !((state == DRAW) && wheel);
`else
      plot_d   = raster;
`endif
      done_d   = (state == DONE) && (state_nxt == DONE);
      move_en  = (state == IDLE) && bus.drive && !done_race && !bus.resetsignal;
      x_nxt    = car_x;
      y_nxt    = car_y;
      if (move_en) begin
         if (bus.straight)
            y_nxt = (car_y < 7'(STEP_Y)) ? 7'd0 : car_y - 7'(STEP_Y);
         else if (bus.left)
            x_nxt = (car_x < 8'(X_MIN + STEP_X)) ? 8'(X_MIN) : car_x - 8'(STEP_X);
         else if (bus.right)
            x_nxt = (car_x > 8'(X_MAX - STEP_X)) ? 8'(X_MAX) : car_x + 8'(STEP_X);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         car_x      <= 8'(START_X);
         car_y      <= 7'(START_Y);
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         done_car   <= 1'b0;
         done_clear <= 1'b0;
         done_race  <= 1'b0;
         mode_draw  <= 1'b0;
         cx         <= '0;
         cy         <= '0;
      end else if (bus.resetsignal) begin
         car_x      <= 8'(START_X);
         car_y      <= 7'(START_Y);
         vga_plot   <= 1'b0;
         done_car   <= 1'b0;
         done_clear <= 1'b0;
         done_race  <= 1'b0;
         cx         <= '0;
         cy         <= '0;
      end else begin
         car_x      <= x_nxt;
         car_y      <= y_nxt;
         if (move_en && (y_nxt <= 7'(FINISH_Y))) done_race <= 1'b1;
         vga_plot   <= plot_d;
         done_car   <= done_d && mode_draw;
         done_clear <= done_d && !mode_draw;
         if (state == IDLE) begin
            // clear wins over draw_car, so the mode latched on exit matches the chosen state
            cx        <= '0;
            cy        <= '0;
            mode_draw <= !bus.clear;
         end else if (raster) begin
            vga_x      <= car_x + 8'(cx);
            vga_y      <= car_y + 7'(cy);
            vga_colour <= colour_d;
            if (cx == CX_LAST) begin
               cx <= '0;
               cy <= (cy == CY_LAST) ? '0 : cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

   assign bus.vga_x      = vga_x;
   assign bus.vga_y      = vga_y;
   assign bus.vga_colour = vga_colour;
   assign bus.vga_plot   = vga_plot;
   assign bus.done_car   = done_car;
   assign bus.done_clear = done_clear;
   assign bus.done_race  = done_race;
   assign bus.car_x      = car_x;
   assign bus.car_y      = car_y;
endmodule

// File: doc/car_pixel_engine.md
Name: car_pixel_engine

Overview:
- Datapath stage directly downstream of the race control FSM.
- Holds the car position and applies move commands (drive with straight/left/right).
- Rasterises the car sprite (draw_car) or erases it with the background colour (clear), one pixel per clock, into the VGA adapter's write port.
- Returns the done_car, done_clear and done_race handshakes to the control FSM.

Parameters:
- CAR_W, 8, sprite width in pixels
- CAR_H, 12, sprite height in pixels
- START_X, 76, reset/restart x of the sprite's top-left corner
- START_Y, 100, reset/restart y of the sprite's top-left corner
- STEP_X, 4, lateral move per drive pulse
- STEP_Y, 2, forward move per drive pulse
- X_MIN, 20, leftmost legal x
- X_MAX, 132, rightmost legal x (top-left corner)
- FINISH_Y, 8, y at or below which the race is won
- CAR_COLOUR, 3'b100, body colour
- BG_COLOUR, 3'b010, erase colour

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- draw_car  in  1  level request: rasterise sprite at current position
- clear  in  1  level request: erase sprite footprint at current position
- drive  in  1  single-cycle move strobe
- straight  in  1  move qualifier: forward
- left  in  1  move qualifier: left
- right  in  1  move qualifier: right
- resetsignal  in  1  synchronous restart to start position
- vga_x  out  8  pixel x (0..159)
- vga_y  out  7  pixel y (0..119)
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable
- done_car  out  1  draw complete
- done_clear  out  1  erase complete
- done_race  out  1  car has reached the finish line
- car_x  out  8  current x
- car_y  out  7  current y

Behaviour:
- Reset values: car_x=START_X, car_y=START_Y; vga_x=0, vga_y=0, vga_colour=0; vga_plot, done_car, done_clear and done_race all 0; FSM=IDLE; counters cx=cy=0.
- FSM states: IDLE, DRAW, ERASE, DONE.
- IDLE:
  - clear=1 -> ERASE. clear has priority when clear and draw_car are both high.
  - else draw_car=1 -> DRAW.
  - cx and cy are zeroed on entry to DRAW or ERASE.
- DRAW/ERASE:
  - Each cycle register vga_x=car_x+cx, vga_y=car_y+cy, vga_plot=1.
  - cx increments 0..CAR_W-1, then wraps to 0 and cy increments.
  - After pixel (CAR_W-1, CAR_H-1) -> DONE.
  - Outputs are registered, so the first plot appears 1 cycle after leaving IDLE. Exactly CAR_W*CAR_H plot cycles occur (96 at defaults).
- DRAW colour:
  - 3'b000 (wheel) when cx is 0 or CAR_W-1 AND (cy<3 or cy>=CAR_H-3).
  - Otherwise CAR_COLOUR.
- ERASE colour: BG_COLOUR for every pixel.
- DONE:
  - vga_plot=0.
  - done_car=1 if entered from DRAW; done_clear=1 if entered from ERASE.
  - Held until the corresponding request goes low, then -> IDLE with done deasserted in the same edge.
- Requests that drop mid-raster do not abort the raster; the raster completes.
- Moves (drive=1) are honoured only in IDLE; drive in any other state is ignored.
  - Priority: straight > left > right.
  - straight: car_y -= STEP_Y, saturating at 0.
  - left: car_x = max(car_x-STEP_X, X_MIN).
  - right: car_x = min(car_x+STEP_X, X_MAX).
  - drive with no qualifier set: no change.
- done_race is set when car_y <= FINISH_Y after an update (registered, 1 cycle after the move). It is sticky and cleared only by resetsignal or resetn. Moves are ignored while done_race=1.
- resetsignal (any state):
  - Next edge: car_x/car_y reload START values, done_race=0, FSM=IDLE.
  - vga_plot, done_car and done_clear are 0; any raster in progress is aborted.
  - resetsignal has priority over drive and requests in the same cycle.
- resetn asserted mid-raster: immediate return to reset values, no further plots.

Optional Feature:
- Macro CAR_TRANSPARENT_EN.
- Defined: wheel-coded pixels in DRAW are skipped (vga_plot=0 for those cycles, coordinates still advance). DRAW still takes CAR_W*CAR_H cycles but issues CAR_W*CAR_H-12 plots (84 at defaults). ERASE is unchanged.
- Undefined: wheels are plotted in colour 3'b000 as specified above.

Test Plan:
- Reset, then draw_car held high -> first plot 1 cycle later at (76,100) colour 3'b000; 96 plots total; last plot at (83,111); done_car=1 next cycle; done_car drops 1 cycle after draw_car drops.
- clear and draw_car raised together -> ERASE runs, 96 plots all colour 3'b010, done_clear=1 and done_car stays 0.
- drive+left pulsed 20 times from START_X=76 -> car_x steps 72, 68, ... then saturates at 20; drive+right pulsed 40 times -> saturates at 132.
- drive+straight pulsed 46 times -> car_y 100 -> 8; done_race=1 one cycle after the 46th pulse; a further drive+left leaves car_x unchanged.
- resetsignal asserted mid-DRAW at pixel 30 -> next cycle vga_plot=0, FSM=IDLE, car at (76,100), done_race=0, no done_car pulse.
- drive pulsed during DRAW -> position unchanged. With CAR_TRANSPARENT_EN defined, a full draw -> exactly 84 plots in 96 cycles.
